led_matrix_scan: RTL
====================

Name: led_matrix_scan

Overview:
Parametrised successor to the single-column iceFUN LED blinker. Drives an NUM_ROWS x NUM_COLS active-low LED matrix by time-multiplexing columns with blanking dead time between them. Display source is either a free-running counter pattern or a double-buffered frame buffer loaded over a simple write port. Sits at top level between board pins and user logic.

Parameters:
NUM_ROWS, 8, row (LED) lines per column
NUM_COLS, 4, column enable lines scanned in turn
SCAN_DIV, 3000, clk cycles a column is driven (DRIVE dwell), >= 2
BLANK_CYCLES, 16, clk cycles all outputs off between columns, >= 1
CNT_W, 32, free-running counter width
PAT_LSB, 19, lowest counter bit shown in counter mode; PAT_LSB+NUM_ROWS <= CNT_W

Ports:
clk  in  1  system clock (12 MHz on iceFUN)
rst_n  in  1  asynchronous active-low reset
mode  in  1  0 = counter pattern, 1 = frame buffer
wr_en  in  1  write one column of the shadow buffer
wr_col  in  CW=max(1,$clog2(NUM_COLS))  column index for write
wr_data  in  NUM_ROWS  column data, 1 = LED lit
wr_commit  in  1  request shadow->active swap
wr_ready  out  1  high when writes/commits are accepted
frame_start  out  1  one-cycle pulse when column 0 begins DRIVE
led_n  out  NUM_ROWS  row drive, active low
lcol_n  out  NUM_COLS  column enable, active low

Behaviour:
- Reset (async, rst_n=0): led_n all 1, lcol_n all 1, frame_start 0, wr_ready 1, counter 0, col 0, FSM BLANK, both buffers cleared, commit_pending 0. Outputs go off immediately, not at next edge; reset mid-DRIVE is legal.
- Counter: cnt increments by 1 every clk, wraps at 2^CNT_W-1 -> 0.
- FSM: BLANK -> DRIVE after BLANK_CYCLES cycles; DRIVE -> BLANK after SCAN_DIV cycles, col advances, NUM_COLS-1 wraps to 0. After reset the first DRIVE is column 0, entered after BLANK_CYCLES cycles.
- BLANK: led_n and lcol_n all 1.
- DRIVE: lcol_n[col]=0, others 1; led_n = ~pix, pix latched on the BLANK->DRIVE edge and held for the whole dwell.
- pix source, sampled at DRIVE entry: mode=1 -> active[col]; mode=0 -> cnt[PAT_LSB +: NUM_ROWS] rotated left by col. A mode change mid-dwell applies from the next DRIVE.
- frame_start: high for exactly the first DRIVE cycle of column 0.
- Write port: wr_en && wr_ready writes wr_data to shadow[wr_col]. wr_col >= NUM_COLS is ignored.
- Commit: wr_commit && wr_ready sets commit_pending; wr_ready drops the next cycle. Writes and commits while wr_ready=0 are ignored.
- Swap: on the BLANK->DRIVE transition into column 0, if commit_pending then active <= shadow, commit_pending <= 0, and wr_ready=1 the following cycle. The swapped data is displayed in that same DRIVE, so no frame ever mixes old and new data.
- Same-cycle wr_en and wr_commit: the write is included in the commit.

Optional Feature:
LED_PWM_EN: adds input brightness[3:0]. A 4-bit pwm counter runs only during DRIVE and clears on DRIVE entry. Rows follow pix while pwm <= brightness, otherwise led_n all 1; lcol_n is unchanged. brightness is sampled at DRIVE entry. brightness=15 gives full on. Without the macro there is no port and rows are always full on during DRIVE.

Decomposition:
- Package led_matrix_pkg: mode encodings, FSM state enum (BLANK, DRIVE), column index width function.
- One natural sub-module, led_frame_buf: shadow/active registers, write decode, commit/swap handshake. The scan FSM stays in led_matrix_scan.

Test Plan:
All scenarios use NUM_ROWS=8, NUM_COLS=4, SCAN_DIV=8, BLANK_CYCLES=2, PAT_LSB=0.
1. Reset, mode=0 -> 2 cycles all off, then lcol_n=4'b1110 for 8 cycles, 2 off, then 4'b1101, through 1011 and 0111, wrapping to 1110. frame_start pulses every 40 cycles.
2. mode=0 -> led_n at each DRIVE entry equals ~rotl(cnt[7:0], col), checked against the reference counter.
3. mode=1; write cols 0..3 = 8'h01, 8'h02, 8'h04, 8'h08; commit mid-frame -> wr_ready=0 until the next column-0 entry; from that frame led_n = 8'hFE, FD, FB, F7 per column, with no earlier frame showing new data.
4. Write while wr_ready=0, and wr_col=5 -> both ignored, displayed data unchanged. Same-cycle wr_en (col 2, 8'hAA) + wr_commit -> column 2 shows led_n=8'h55.
5. Assert rst_n low mid-DRIVE of column 2 -> outputs all 1 within the same cycle (before the next clk edge). After release, scanning restarts at column 0 and the buffer is cleared (led_n=8'hFF in mode 1).
6. LED_PWM_EN, brightness=3, pix=8'hFF -> each 8-cycle dwell shows led_n=8'h00 for 4 cycles, then 8'hFF for 4 cycles.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the LED matrix scanner and its frame buffer.
package led_matrix_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  typedef enum logic {
    MODE_COUNTER = 1'b0,
    MODE_FRAME   = 1'b1
  } src_mode_t;

  // Index width for n items, never narrower than one bit.
  function automatic int col_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_frame_buf.sv
// Double-buffered column store: shadow written by user logic, active shown on the matrix.
// Commit/swap handshake keeps every displayed frame entirely old or entirely new.
module led_frame_buf
  import led_matrix_pkg::*;
#(
  parameter int NUM_ROWS = 8,
  parameter int NUM_COLS = 4,
  parameter int CW       = col_w(NUM_COLS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_col,
  input  logic [NUM_ROWS-1:0] wr_data,
  input  logic                wr_commit,
  input  logic                swap_req,
  input  logic [CW-1:0]       rd_col,
  output logic [NUM_ROWS-1:0] rd_data,
  output logic                wr_ready
);

  logic [NUM_ROWS-1:0] shadow_q [NUM_COLS];
  logic [NUM_ROWS-1:0] active_q [NUM_COLS];
  logic                commit_pending_q;
  logic                wr_ok;
  logic                commit_ok;
  logic                do_swap;

  assign wr_ready  = ~commit_pending_q;
  assign wr_ok     = wr_en && wr_ready && (32'(wr_col) < NUM_COLS);
  assign commit_ok = wr_commit && wr_ready;
  assign do_swap   = swap_req && commit_pending_q;

  // NOTE: both buffers are a handful of flops, so they are reset like any other
  // register; a large RAM-style store would normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COLS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      commit_pending_q <= 1'b0;
    end else begin
      // Writes are blocked while a commit is pending, so they never race the swap.
      if (wr_ok) shadow_q[wr_col] <= wr_data;
      if (do_swap) begin
        active_q         <= shadow_q;
        commit_pending_q <= 1'b0;
      end else if (commit_ok) begin
        commit_pending_q <= 1'b1;
      end
    end
  end

  // On the swap edge the scanner latches the new data directly from shadow,
  // so the first frame after a commit already shows it.
  assign rd_data = do_swap ? shadow_q[rd_col] : active_q[rd_col];

endmodule

// File: rtl/led_matrix_scan.sv
// Column-multiplexed active-low LED matrix driver with blanking between columns.
// Optional LED_PWM_EN adds a 4-bit brightness input that gates rows within each dwell.
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int NUM_ROWS     = 8,
  parameter int NUM_COLS     = 4,
  parameter int SCAN_DIV     = 3000,
  parameter int BLANK_CYCLES = 16,
  parameter int CNT_W        = 32,
  parameter int PAT_LSB      = 19
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mode,
  input  logic                        wr_en,
  input  logic [col_w(NUM_COLS)-1:0]  wr_col,
  input  logic [NUM_ROWS-1:0]         wr_data,
  input  logic                        wr_commit,
`ifdef LED_PWM_EN
  input  logic [3:0]                  brightness,
`endif
  output logic                        wr_ready,
  output logic                        frame_start,
  output logic [NUM_ROWS-1:0]         led_n,
  output logic [NUM_COLS-1:0]         lcol_n
);

  localparam int CW      = col_w(NUM_COLS);
  localparam int TMR_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int TW      = col_w(TMR_MAX);

  scan_state_t         state_q, state_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [CW-1:0]       col_q, col_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_ROWS-1:0] pix_q;
  logic [NUM_ROWS-1:0] pat, pat_rot, fb_rd, pix_src;
  logic                enter_drive;
  logic                row_on;
  logic                unused_cnt;

  // Every counter bit is kept so the pattern window can be moved by parameter alone.
  assign unused_cnt = ^cnt_q;

  // NOTE: every signal written here gets a default first; a path that left one
  // unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q + TW'(1);
    col_d       = col_q;
    enter_drive = 1'b0;
    unique case (state_q)
      BLANK: begin
        if (tmr_q == TW'(BLANK_CYCLES - 1)) begin
          state_d     = DRIVE;
          tmr_d       = '0;
          enter_drive = 1'b1;
        end
      end
      DRIVE: begin
        if (tmr_q == TW'(SCAN_DIV - 1)) begin
          state_d = BLANK;
          tmr_d   = '0;
          col_d   = (col_q == CW'(NUM_COLS - 1)) ? '0 : col_q + CW'(1);
        end
      end
      default: begin
        state_d = BLANK;
        tmr_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BLANK;
      tmr_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      col_q   <= col_d;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (enter_drive) pix_q <= pix_src;
    end
  end

  // Counter pattern rotated left by the column index so columns look distinct.
  always_comb begin
    int rot_amt;
    pat     = cnt_q[PAT_LSB +: NUM_ROWS];
    rot_amt = 32'(col_q) % NUM_ROWS;
    pat_rot = '0;
    for (int j = 0; j < NUM_ROWS; j++) begin
      pat_rot[j] = pat[(j + NUM_ROWS - rot_amt) % NUM_ROWS];
    end
  end

  assign pix_src = (src_mode_t'(mode) == MODE_FRAME) ? fb_rd : pat_rot;

  led_frame_buf #(
    .NUM_ROWS (NUM_ROWS),
    .NUM_COLS (NUM_COLS),
    .CW       (CW)
  ) u_frame_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .wr_commit (wr_commit),
    .swap_req  (enter_drive && (col_q == '0)),
    .rd_col    (col_q),
    .rd_data   (fb_rd),
    .wr_ready  (wr_ready)
  );

`ifdef LED_PWM_EN
  logic [3:0] pwm_q;
  logic [3:0] bri_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= '0;
      bri_q <= '0;
    end else if (enter_drive) begin
      pwm_q <= '0;
      bri_q <= brightness;
    end else if (state_q == DRIVE) begin
      pwm_q <= pwm_q + 4'd1;
    end
  end

  assign row_on = (pwm_q <= bri_q);
`else
  assign row_on = 1'b1;
`endif

  // Outputs decode straight from reset-cleared state, so reset blanks them at once.
  always_comb begin
    lcol_n = '1;
    led_n  = '1;
    if (state_q == DRIVE) begin
      lcol_n = ~(NUM_COLS'(1) << col_q);
      if (row_on) led_n = ~pix_q;
    end
  end

  assign frame_start = (state_q == DRIVE) && (col_q == '0) && (tmr_q == '0);

endmodule
